// File: rtl/tse_phy_speed_poller_if.sv
// MDIO pad bundle between the speed poller (master) and the PHY/pad side (slave).
// mdio_oen is active-low: 0 = master drives mdio_out onto the pad.
interface tse_phy_speed_poller_if;
   logic mdc;
   logic mdio_in;
   logic mdio_out;
   logic mdio_oen;

   modport master (output mdc, output mdio_out, output mdio_oen, input mdio_in);
   modport slave  (input mdc, input mdio_out, input mdio_oen, output mdio_in);
endinterface

// File: rtl/tse_phy_speed_poller.sv
// Clause 22 MDIO read master: periodically reads the PHY status register,
// then decodes link/speed into the TSE MAC set_10/set_1000 status inputs.
module tse_phy_speed_poller #(
   parameter int unsigned CLK_DIV  = 25,
   parameter logic [4:0]  PHY_ADDR = 5'd0,
   parameter logic [4:0]  STAT_REG = 5'd17,
   parameter int unsigned POLL_CYC = 50_000_000
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset_n,
   input  logic                          enable,
   tse_phy_speed_poller_if.master        mdio,
   output logic                          set_10,
   output logic                          set_1000,
   output logic                          link_up,
   output logic [15:0]                   status_data,
   output logic                          status_valid,
   output logic                          read_err
);
   localparam int unsigned    DIV_W     = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [31:0]    POLL_LOAD = 32'(POLL_CYC);
   localparam logic [13:0]    HDR       = {2'b01, 2'b10, PHY_ADDR, STAT_REG};
   localparam logic [5:0]     TA_FIRST  = 6'd46;
   localparam logic [5:0]     TA_LAST   = 6'd47;
   localparam logic [5:0]     BIT_LAST  = 6'd63;

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE, S_WAIT
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [5:0]        bit_q, bit_d;
   logic [31:0]       wait_q, wait_d;
   logic              mdc_q, mdc_d;
   logic              out_q, out_d;
   logic              oen_q, oen_d;
   logic              ta_q, ta_d;
   logic [15:0]       shift_q, shift_d;
   logic              set10_q, set10_d;
   logic              set1000_q, set1000_d;
   logic              link_q, link_d;
   logic [15:0]       data_q, data_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;

   logic [5:0]        nxt_bit;
   logic              tick;
   logic              start;

   assign nxt_bit = bit_q + 6'd1;
   assign tick    = (div_q == DIV_LAST);

   // Frame bit index -> protocol field.
   function automatic state_t state_for(input logic [5:0] b);
      if (b < 6'd32)         return S_PRE;
      else if (b < TA_FIRST) return S_HDR;
      else if (b <= TA_LAST) return S_TA;
      else                   return S_DATA;
   endfunction

   // Value placed on the pad for frame bit b; TA/DATA are released, keep the idle 1.
   function automatic logic bit_val(input logic [5:0] b);
      logic [5:0] idx;
      idx = 6'd45 - b;
      if (b < 6'd32)         return 1'b1;
      else if (b < TA_FIRST) return HDR[idx[3:0]];
      else                   return 1'b1;
   endfunction

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      wait_d    = wait_q;
      mdc_d     = mdc_q;
      out_d     = out_q;
      oen_d     = oen_q;
      ta_d      = ta_q;
      shift_d   = shift_q;
      set10_d   = set10_q;
      set1000_d = set1000_q;
      link_d    = link_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      err_d     = err_q;
      start     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (enable) start = 1'b1;
         end
         S_PRE, S_HDR, S_TA, S_DATA: begin
            if (!tick) begin
               div_d = div_q + 1'b1;
            end else begin
               div_d = '0;
               if (!mdc_q) begin
                  // Rising MDC: the PHY's bit has been stable for a full low phase.
                  mdc_d = 1'b1;
                  if (bit_q == TA_LAST) ta_d = mdio.mdio_in;
                  if (state_q == S_DATA) shift_d = {shift_q[14:0], mdio.mdio_in};
               end else begin
                  mdc_d = 1'b0;
                  if (bit_q == BIT_LAST) begin
                     state_d = S_DONE;
                  end else begin
                     bit_d   = nxt_bit;
                     state_d = state_for(nxt_bit);
                     out_d   = bit_val(nxt_bit);
                     oen_d   = (nxt_bit >= TA_FIRST);
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_WAIT;
            wait_d  = POLL_LOAD;
            if (ta_q) begin
               err_d = 1'b1;
            end else begin
               err_d   = 1'b0;
               data_d  = shift_q;
               valid_d = 1'b1;
               link_d  = shift_q[10];
               // Only a resolved, up link may change the MAC mode; 2'b11 is reserved.
               if (shift_q[10] && shift_q[11]) begin
                  case (shift_q[15:14])
                     2'b10:   begin set1000_d = 1'b1; set10_d = 1'b0; end
                     2'b01:   begin set1000_d = 1'b0; set10_d = 1'b0; end
                     2'b00:   begin set1000_d = 1'b0; set10_d = 1'b1; end
                     default: ;
                  endcase
               end
            end
         end
         S_WAIT: begin
            if (wait_q == 32'd1) begin
               if (enable) start = 1'b1;
               else        state_d = S_IDLE;
            end else begin
               wait_d = wait_q - 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (start) begin
         state_d = S_PRE;
         bit_d   = '0;
         div_d   = '0;
         mdc_d   = 1'b0;
         out_d   = bit_val(6'd0);
         oen_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q   <= S_IDLE;
         div_q     <= '0;
         bit_q     <= '0;
         wait_q    <= '0;
         mdc_q     <= 1'b0;
         out_q     <= 1'b1;
         oen_q     <= 1'b1;
         ta_q      <= 1'b0;
         shift_q   <= '0;
         set10_q   <= 1'b0;
         set1000_q <= 1'b0;
         link_q    <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         wait_q    <= wait_d;
         mdc_q     <= mdc_d;
         out_q     <= out_d;
         oen_q     <= oen_d;
         ta_q      <= ta_d;
         shift_q   <= shift_d;
         set10_q   <= set10_d;
         set1000_q <= set1000_d;
         link_q    <= link_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   assign mdio.mdc      = mdc_q;
   assign mdio.mdio_out = out_q;
   assign mdio.mdio_oen = oen_q;
   assign set_10        = set10_q;
   assign set_1000      = set1000_q;
   assign link_up       = link_q;
   assign status_data   = data_q;
   assign status_valid  = valid_q;
   assign read_err      = err_q;
endmodule
